// File: rtl/ddr3_cmd_arb_pkg.sv
// Shared encodings for the DDR3 command arbiter: DDR3 command codes
// ({RAS_n,CAS_n,WE_n}) and the arbiter state encoding.
package ddr3_cmd_arb_pkg;

    typedef enum logic [2:0] {
        CMD_MODE = 3'b000,
        CMD_REFR = 3'b001,
        CMD_PREC = 3'b010,
        CMD_ACTV = 3'b011,
        CMD_WRIT = 3'b100,
        CMD_READ = 3'b101,
        CMD_ZQCL = 3'b110,
        CMD_NOOP = 3'b111
    } ddr_cmd_t;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_FSM  = 3'd2,
        ST_PREA = 3'd3,
        ST_REFR = 3'd4
    } arb_state_t;

    localparam int DEBT_W = 4;

endpackage

// File: rtl/ddr3_cmd_arb_ref_debt.sv
// Refresh debt tracker: saturating up/down counter of postponed refreshes
// with a sticky overflow flag (a tREFI tick arrived while already at the limit).
module ddr3_cmd_arb_ref_debt
    import ddr3_cmd_arb_pkg::*;
#(
    parameter int REF_MAX = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              inc_i,
    input  logic              dec_i,
    output logic [DEBT_W-1:0] debt_o,
    output logic              err_o
);

    localparam logic [DEBT_W-1:0] REF_MAX_L = DEBT_W'(REF_MAX);

    logic [DEBT_W-1:0] debt_r;
    logic              err_r;

    // Debt counter: clear wins, a tick and a completed refresh cancel out.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            debt_r <= {DEBT_W{1'b0}};
            err_r  <= 1'b0;
        end else if (clr_i) begin
            debt_r <= {DEBT_W{1'b0}};
        end else begin
            case ({inc_i, dec_i})
                2'b10: begin
                    if (debt_r == REF_MAX_L) begin
                        err_r <= 1'b1;
                    end else begin
                        debt_r <= debt_r + 4'd1;
                    end
                end
                2'b01: begin
                    if (debt_r != 4'd0) begin
                        debt_r <= debt_r - 4'd1;
                    end
                end
                default: begin
                    debt_r <= debt_r;
                end
            endcase
        end
    end

    assign debt_o = debt_r;
    assign err_o  = err_r;

endmodule

// File: rtl/ddr3_cmd_arb.sv
// DDR3 command-port arbiter. The configurator owns the DDL command port until
// cfg_run_i; afterwards refresh debt is tracked and PREA+REFR is inserted when
// the controller FSM is idle or the debt is urgent, otherwise the FSM is granted.
// Optional feature macro: ARB_REF_BURST_EN (back-to-back REFR while debt remains).
module ddr3_cmd_arb
    import ddr3_cmd_arb_pkg::*;
#(
    parameter int DDR_ROW_BITS = 13,
    parameter int REF_MAX      = 8,
    parameter int REF_URGENT   = 6
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cfg_run_i,
    input  logic                    cfg_req_i,
    output logic                    cfg_rdy_o,
    input  logic [2:0]              cfg_cmd_i,
    input  logic [2:0]              cfg_ba_i,
    input  logic [DDR_ROW_BITS-1:0] cfg_adr_i,
    input  logic                    cfg_ref_i,
    input  logic                    fsm_req_i,
    input  logic                    fsm_seq_i,
    output logic                    fsm_rdy_o,
    input  logic [2:0]              fsm_cmd_i,
    input  logic [2:0]              fsm_ba_i,
    input  logic [DDR_ROW_BITS-1:0] fsm_adr_i,
    output logic                    ddl_req_o,
    output logic                    ddl_seq_o,
    input  logic                    ddl_rdy_i,
    output logic [2:0]              ddl_cmd_o,
    output logic [2:0]              ddl_ba_o,
    output logic [DDR_ROW_BITS-1:0] ddl_adr_o,
    output logic [3:0]              ref_debt_o,
    output logic                    ref_err_o
);

    localparam logic [DEBT_W-1:0] URGENT_L = DEBT_W'(REF_URGENT);

    arb_state_t              state_r;
    ddr_cmd_t                ref_cmd_r;
    logic                    ref_req_r;
    logic                    ref_seq_r;
    logic                    ref_a10_r;
    logic [DDR_ROW_BITS-1:0] ref_adr_s;
    logic [DEBT_W-1:0]       debt_s;
    logic                    debt_urgent_s;
    logic                    ref_due_s;
    logic                    fsm_grant_s;
    logic                    xfer_s;
    logic                    abort_s;
    logic                    ref_inc_s;
    logic                    ref_dec_s;
    logic                    burst_more_s;

    assign debt_urgent_s = (debt_s >= URGENT_L);
    assign ref_due_s     = ((debt_s != 4'd0) && !fsm_req_i) || debt_urgent_s;
    // The FSM can only be granted from IDLE while running and not refresh-starved.
    assign fsm_grant_s   = cfg_run_i && fsm_req_i && !debt_urgent_s;
    assign xfer_s        = ddl_req_o && ddl_rdy_i;
    // Losing cfg_run_i returns the port to the configurator, but never splits a
    // command that is currently being offered to the DDL.
    assign abort_s       = !cfg_run_i && (state_r != ST_INIT) && (!ddl_req_o || xfer_s);
    assign ref_inc_s     = cfg_ref_i && (state_r != ST_INIT);
    assign ref_dec_s     = (state_r == ST_REFR) && xfer_s;

`ifdef ARB_REF_BURST_EN
    logic [DEBT_W-1:0] debt_next_s;
    assign debt_next_s  = ref_inc_s ? debt_s : (debt_s - 4'd1);
    // Keep refreshing while debt remains, unless the FSM waits and debt is tolerable.
    assign burst_more_s = (debt_next_s != 4'd0) && !(fsm_req_i && (debt_next_s < URGENT_L));
`else
    assign burst_more_s = 1'b0;
`endif

    ddr3_cmd_arb_ref_debt #(
        .REF_MAX (REF_MAX)
    ) u_ref_debt (
        .clock  (clock),
        .reset  (reset),
        .clr_i  (abort_s),
        .inc_i  (ref_inc_s),
        .dec_i  (ref_dec_s),
        .debt_o (debt_s),
        .err_o  (ref_err_o)
    );

    assign ref_debt_o = debt_s;

    // Refresh command address: all-bank precharge needs A10 set, other bits zero.
    always_comb begin
        ref_adr_s     = {DDR_ROW_BITS{1'b0}};
        ref_adr_s[10] = ref_a10_r;
    end

    // Command-port mux: the current owner drives ddl_* and sees ddl_rdy_i.
    always_comb begin
        ddl_req_o = 1'b0;
        ddl_seq_o = 1'b0;
        ddl_cmd_o = CMD_NOOP;
        ddl_ba_o  = 3'b000;
        ddl_adr_o = {DDR_ROW_BITS{1'b0}};
        cfg_rdy_o = 1'b0;
        fsm_rdy_o = 1'b0;
        case (state_r)
            ST_INIT: begin
                ddl_req_o = cfg_req_i;
                ddl_cmd_o = cfg_cmd_i;
                ddl_ba_o  = cfg_ba_i;
                ddl_adr_o = cfg_adr_i;
                cfg_rdy_o = ddl_rdy_i;
            end
            ST_IDLE: begin
                if (fsm_grant_s) begin
                    ddl_req_o = fsm_req_i;
                    ddl_seq_o = fsm_seq_i;
                    ddl_cmd_o = fsm_cmd_i;
                    ddl_ba_o  = fsm_ba_i;
                    ddl_adr_o = fsm_adr_i;
                    fsm_rdy_o = ddl_rdy_i;
                end else begin
                    ddl_req_o = 1'b0;
                    fsm_rdy_o = 1'b0;
                end
            end
            ST_FSM: begin
                ddl_req_o = fsm_req_i;
                ddl_seq_o = fsm_seq_i;
                ddl_cmd_o = fsm_cmd_i;
                ddl_ba_o  = fsm_ba_i;
                ddl_adr_o = fsm_adr_i;
                fsm_rdy_o = ddl_rdy_i;
            end
            ST_PREA, ST_REFR: begin
                ddl_req_o = ref_req_r;
                ddl_seq_o = ref_seq_r;
                ddl_cmd_o = ref_cmd_r;
                ddl_adr_o = ref_adr_s;
            end
            default: begin
                ddl_req_o = 1'b0;
            end
        endcase
    end

    // Ownership FSM with registered refresh-command fields.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= ST_INIT;
            ref_req_r <= 1'b0;
            ref_seq_r <= 1'b0;
            ref_a10_r <= 1'b0;
            ref_cmd_r <= CMD_NOOP;
        end else if (abort_s) begin
            state_r   <= ST_INIT;
            ref_req_r <= 1'b0;
            ref_seq_r <= 1'b0;
            ref_a10_r <= 1'b0;
            ref_cmd_r <= CMD_NOOP;
        end else begin
            case (state_r)
                ST_INIT: begin
                    if (cfg_run_i) begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (ref_due_s) begin
                        state_r   <= ST_PREA;
                        ref_req_r <= 1'b1;
                        ref_seq_r <= 1'b1;
                        ref_a10_r <= 1'b1;
                        ref_cmd_r <= CMD_PREC;
                    end else if (fsm_grant_s && !(xfer_s && !fsm_seq_i)) begin
                        state_r <= ST_FSM;
                    end
                end
                ST_FSM: begin
                    if (xfer_s && !fsm_seq_i) begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_PREA: begin
                    if (xfer_s) begin
                        state_r   <= ST_REFR;
                        ref_seq_r <= 1'b0;
                        ref_a10_r <= 1'b0;
                        ref_cmd_r <= CMD_REFR;
                    end
                end
                ST_REFR: begin
                    if (xfer_s && !burst_more_s) begin
                        state_r   <= ST_IDLE;
                        ref_req_r <= 1'b0;
                        ref_cmd_r <= CMD_NOOP;
                    end
                end
                default: begin
                    state_r   <= ST_INIT;
                    ref_req_r <= 1'b0;
                    ref_cmd_r <= CMD_NOOP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_cmd_arb.sv
// Self-checking bench for ddr3_cmd_arb: configurator pass-through table,
// refresh insertion, FSM sequences, debt saturation and async reset.
module tb_ddr3_cmd_arb;

    logic        clock = 1'b0;
    logic        reset;
    logic        cfg_run_i, cfg_req_i, cfg_ref_i, cfg_rdy_o;
    logic [2:0]  cfg_cmd_i, cfg_ba_i;
    logic [12:0] cfg_adr_i;
    logic        fsm_req_i, fsm_seq_i, fsm_rdy_o;
    logic [2:0]  fsm_cmd_i, fsm_ba_i;
    logic [12:0] fsm_adr_i;
    logic        ddl_req_o, ddl_seq_o, ddl_rdy_i;
    logic [2:0]  ddl_cmd_o, ddl_ba_o;
    logic [12:0] ddl_adr_o;
    logic [3:0]  ref_debt_o;
    logic        ref_err_o;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] C_MODE = 3'b000, C_REFR = 3'b001, C_PREC = 3'b010,
                           C_ACTV = 3'b011, C_WRIT = 3'b100, C_READ = 3'b101,
                           C_ZQCL = 3'b110, C_NOOP = 3'b111;

    typedef struct packed {
        logic [2:0]  cmd;
        logic [2:0]  ba;
        logic [12:0] adr;
        logic        seq;
    } xfer_t;

    typedef struct packed {
        logic        cfg_req;
        logic [2:0]  cfg_cmd;
        logic [2:0]  cfg_ba;
        logic [12:0] cfg_adr;
        logic        fsm_req;
        logic        rdy;
        logic        ref_p;
        logic        exp_req;
        logic [2:0]  exp_cmd;
        logic [2:0]  exp_ba;
        logic [12:0] exp_adr;
        logic        exp_cfg_rdy;
        logic        exp_fsm_rdy;
    } vec_t;

    xfer_t sb_q[$];
    vec_t  vecs[4];

    ddr3_cmd_arb dut (
        .clock      (clock),
        .reset      (reset),
        .cfg_run_i  (cfg_run_i),
        .cfg_req_i  (cfg_req_i),
        .cfg_rdy_o  (cfg_rdy_o),
        .cfg_cmd_i  (cfg_cmd_i),
        .cfg_ba_i   (cfg_ba_i),
        .cfg_adr_i  (cfg_adr_i),
        .cfg_ref_i  (cfg_ref_i),
        .fsm_req_i  (fsm_req_i),
        .fsm_seq_i  (fsm_seq_i),
        .fsm_rdy_o  (fsm_rdy_o),
        .fsm_cmd_i  (fsm_cmd_i),
        .fsm_ba_i   (fsm_ba_i),
        .fsm_adr_i  (fsm_adr_i),
        .ddl_req_o  (ddl_req_o),
        .ddl_seq_o  (ddl_seq_o),
        .ddl_rdy_i  (ddl_rdy_i),
        .ddl_cmd_o  (ddl_cmd_o),
        .ddl_ba_o   (ddl_ba_o),
        .ddl_adr_o  (ddl_adr_o),
        .ref_debt_o (ref_debt_o),
        .ref_err_o  (ref_err_o)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [2:0] cmd, input logic [2:0] ba, input logic [12:0] adr,
                        input logic seq);
        xfer_t x;
        x.cmd = cmd; x.ba = ba; x.adr = adr; x.seq = seq;
        sb_q.push_back(x);
    endtask

    task automatic push_ref_pair();
        push(C_PREC, 3'd0, 13'h0400, 1'b1);
        push(C_REFR, 3'd0, 13'h0000, 1'b0);
    endtask

    task automatic drain(input string nm, input int max_cycles);
        for (int k = 0; k < max_cycles && sb_q.size() != 0; k++) step();
        chk(nm, sb_q.size(), 0);
    endtask

    // Transfer monitor: every accepted DDL command must match the scoreboard head.
    always @(negedge clock) begin
        if (!reset && ddl_req_o && ddl_rdy_i) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL xfer_unexpected: got cmd=%0d ba=%0d adr=0x%0h seq=%0b, expected none",
                         ddl_cmd_o, ddl_ba_o, ddl_adr_o, ddl_seq_o);
            end else begin
                xfer_t e;
                e = sb_q.pop_front();
                chk("xfer", {13'd0, ddl_cmd_o, ddl_ba_o, ddl_adr_o, ddl_seq_o}, {13'd0, e});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, C_MODE, 3'd2, 13'h0520, 1'b0, 1'b0, 1'b0,
                    1'b1, C_MODE, 3'd2, 13'h0520, 1'b0, 1'b0};
        vecs[1] = '{1'b1, C_MODE, 3'd2, 13'h0520, 1'b0, 1'b1, 1'b0,
                    1'b1, C_MODE, 3'd2, 13'h0520, 1'b1, 1'b0};
        vecs[2] = '{1'b1, C_ZQCL, 3'd5, 13'h0400, 1'b1, 1'b1, 1'b0,
                    1'b1, C_ZQCL, 3'd5, 13'h0400, 1'b1, 1'b0};
        vecs[3] = '{1'b0, C_NOOP, 3'd0, 13'h0000, 1'b1, 1'b1, 1'b1,
                    1'b0, C_NOOP, 3'd0, 13'h0000, 1'b1, 1'b0};

        reset = 1'b1;
        cfg_run_i = 1'b0; cfg_req_i = 1'b0; cfg_ref_i = 1'b0;
        cfg_cmd_i = C_NOOP; cfg_ba_i = 3'd0; cfg_adr_i = 13'h0;
        fsm_req_i = 1'b0; fsm_seq_i = 1'b0;
        fsm_cmd_i = C_NOOP; fsm_ba_i = 3'd0; fsm_adr_i = 13'h0;
        ddl_rdy_i = 1'b0;
        step(); step();
        chk("rst_req", ddl_req_o, 1'b0);
        chk("rst_cmd", ddl_cmd_o, C_NOOP);
        chk("rst_debt", ref_debt_o, 4'd0);
        chk("rst_err", ref_err_o, 1'b0);
        reset = 1'b0;
        step();

        // Configurator pass-through while cfg_run_i is low.
        for (int i = 0; i < 4; i++) begin
            cfg_req_i = vecs[i].cfg_req; cfg_cmd_i = vecs[i].cfg_cmd;
            cfg_ba_i  = vecs[i].cfg_ba;  cfg_adr_i = vecs[i].cfg_adr;
            fsm_req_i = vecs[i].fsm_req; ddl_rdy_i = vecs[i].rdy;
            cfg_ref_i = vecs[i].ref_p;
            if (vecs[i].exp_req && vecs[i].rdy)
                push(vecs[i].exp_cmd, vecs[i].exp_ba, vecs[i].exp_adr, 1'b0);
            #1;
            chk($sformatf("t1_req[%0d]", i), ddl_req_o, vecs[i].exp_req);
            chk($sformatf("t1_cmd[%0d]", i), ddl_cmd_o, vecs[i].exp_cmd);
            chk($sformatf("t1_ba[%0d]", i), ddl_ba_o, vecs[i].exp_ba);
            chk($sformatf("t1_adr[%0d]", i), ddl_adr_o, vecs[i].exp_adr);
            chk($sformatf("t1_seq[%0d]", i), ddl_seq_o, 1'b0);
            chk($sformatf("t1_cfg_rdy[%0d]", i), cfg_rdy_o, vecs[i].exp_cfg_rdy);
            chk($sformatf("t1_fsm_rdy[%0d]", i), fsm_rdy_o, vecs[i].exp_fsm_rdy);
            step();
        end
        cfg_req_i = 1'b0; cfg_ref_i = 1'b0; fsm_req_i = 1'b0; ddl_rdy_i = 1'b0;
        chk("t1_ref_ignored", ref_debt_o, 4'd0);

        // Single refresh with the FSM idle: PREC(A10) then REFR.
        cfg_run_i = 1'b1;
        step();
        cfg_ref_i = 1'b1;
        step();
        cfg_ref_i = 1'b0;
        chk("t2_debt1", ref_debt_o, 4'd1);
        step();
        chk("t2_prea_req", ddl_req_o, 1'b1);
        chk("t2_prea_cmd", ddl_cmd_o, C_PREC);
        chk("t2_prea_seq", ddl_seq_o, 1'b1);
        chk("t2_prea_adr", ddl_adr_o, 13'h0400);
        push_ref_pair();
        ddl_rdy_i = 1'b1;
        step();
        chk("t2_refr_cmd", ddl_cmd_o, C_REFR);
        chk("t2_refr_seq", ddl_seq_o, 1'b0);
        step();
        chk("t2_debt0", ref_debt_o, 4'd0);
        chk("t2_idle_req", ddl_req_o, 1'b0);
        chk("t2_sb_empty", sb_q.size(), 0);

        // FSM sequence is not preempted by a refresh tick.
        push(C_ACTV, 3'd1, 13'h0123, 1'b1);
        push(C_WRIT, 3'd1, 13'h0010, 1'b1);
        push(C_PREC, 3'd1, 13'h0000, 1'b0);
        push_ref_pair();
        fsm_req_i = 1'b1; fsm_cmd_i = C_ACTV; fsm_ba_i = 3'd1; fsm_adr_i = 13'h0123;
        fsm_seq_i = 1'b1; cfg_ref_i = 1'b1;
        #1;
        chk("t3_fsm_rdy", fsm_rdy_o, 1'b1);
        chk("t3_cfg_rdy", cfg_rdy_o, 1'b0);
        step();
        cfg_ref_i = 1'b0; fsm_cmd_i = C_WRIT; fsm_adr_i = 13'h0010;
        chk("t3_debt", ref_debt_o, 4'd1);
        step();
        fsm_cmd_i = C_PREC; fsm_adr_i = 13'h0000; fsm_seq_i = 1'b0;
        step();
        fsm_req_i = 1'b0; fsm_cmd_i = C_NOOP;
        drain("t3_drain", 20);
        chk("t3_debt0", ref_debt_o, 4'd0);

        // Continuous FSM traffic: urgent debt blocks the next grant.
        fsm_req_i = 1'b1; fsm_cmd_i = C_READ; fsm_ba_i = 3'd3; fsm_adr_i = 13'h0042;
        fsm_seq_i = 1'b0;
        for (int i = 0; i < 6; i++) push(C_READ, 3'd3, 13'h0042, 1'b0);
        push_ref_pair();
        push(C_READ, 3'd3, 13'h0042, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cfg_ref_i = 1'b1;
            step();
        end
        cfg_ref_i = 1'b0;
        #1;
        chk("t4_blocked_rdy", fsm_rdy_o, 1'b0);
        chk("t4_blocked_req", ddl_req_o, 1'b0);
        chk("t4_debt6", ref_debt_o, 4'd6);
        chk("t4_err", ref_err_o, 1'b0);
        step();
        chk("t4_prec", ddl_cmd_o, C_PREC);
        step();
        chk("t4_refr", ddl_cmd_o, C_REFR);
        step();
        chk("t4_regrant", fsm_rdy_o, 1'b1);
        chk("t4_debt5", ref_debt_o, 4'd5);
        step();
        fsm_req_i = 1'b0; fsm_cmd_i = C_NOOP;
        for (int i = 0; i < 5; i++) push_ref_pair();
        drain("t4_drain", 40);
        chk("t4_debt0", ref_debt_o, 4'd0);
        chk("t4_err_end", ref_err_o, 1'b0);

        // Saturation with the DDL stalled.
        ddl_rdy_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cfg_ref_i = 1'b1; step();
            cfg_ref_i = 1'b0; step();
        end
        chk("t5_debt8", ref_debt_o, 4'd8);
        chk("t5_err0", ref_err_o, 1'b0);
        cfg_ref_i = 1'b1; step();
        cfg_ref_i = 1'b0; step();
        chk("t5_debt_sat", ref_debt_o, 4'd8);
        chk("t5_err1", ref_err_o, 1'b1);
        step(); step();
        chk("t5_err_sticky", ref_err_o, 1'b1);

        // Async reset while a REFR is pending.
        push(C_PREC, 3'd0, 13'h0400, 1'b1);
        ddl_rdy_i = 1'b1;
        step();
        ddl_rdy_i = 1'b0;
        chk("t6_refr_cmd", ddl_cmd_o, C_REFR);
        chk("t6_refr_req", ddl_req_o, 1'b1);
        reset = 1'b1;
        #1;
        chk("t6_req", ddl_req_o, 1'b0);
        chk("t6_cmd", ddl_cmd_o, C_NOOP);
        chk("t6_debt", ref_debt_o, 4'd0);
        chk("t6_err", ref_err_o, 1'b0);
        step();
        ddl_rdy_i = 1'b1;
        #1;
        chk("t6_init_cfg_rdy", cfg_rdy_o, 1'b1);
        chk("t6_init_fsm_rdy", fsm_rdy_o, 1'b0);
        chk("t6_sb_empty", sb_q.size(), 0);
        ddl_rdy_i = 1'b0;
        reset = 1'b0;
        step();

        // Three outstanding refreshes drained with the FSM idle.
        for (int i = 0; i < 3; i++) begin
            cfg_ref_i = 1'b1; step();
            cfg_ref_i = 1'b0; step();
        end
        chk("t7_debt3", ref_debt_o, 4'd3);
`ifdef ARB_REF_BURST_EN
        push(C_PREC, 3'd0, 13'h0400, 1'b1);
        for (int i = 0; i < 3; i++) push(C_REFR, 3'd0, 13'h0000, 1'b0);
`else
        for (int i = 0; i < 3; i++) push_ref_pair();
`endif
        ddl_rdy_i = 1'b1;
        drain("t7_drain", 30);
        chk("t7_debt0", ref_debt_o, 4'd0);
        ddl_rdy_i = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
